// File: rtl/mem_bus_arbiter.sv
// Three-requester arbiter for a time-multiplexed memory bus (fetch, load, store) with fetch
// anti-starvation. Optional one-entry posted store buffer enabled by defining STORE_BUF_EN.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned BUS_W      = 12,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              load_ready,
  input  logic              store_valid,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              store_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              bus_active,
  output logic              bus_rw,
  output logic              bus_commit,
  output logic [BUS_W-1:0]  bus_payload,
  input  logic [BUS_W-1:0]  mem_in,
  output logic              busy
);

  localparam int unsigned StW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {StIdle, StAddr, StRdWait, StRdRsp, StStData} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              id_q, id_d;
  logic              rw_q, rw_d;
  logic [1:0]        lat_q, lat_d;
  logic [StW-1:0]    starve_q, starve_d;

  logic              arb_en, fetch_forced;
  logic              gnt_fetch, gnt_load, gnt_store, gnt_drain, load_hit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Readies are only offered in IDLE and are held low while reset is asserted.
  assign arb_en       = rst && (state_q == StIdle);
  assign fetch_forced = fetch_valid && (starve_q == StW'(STARVE_MAX));
  assign fetch_ready  = gnt_fetch;
  assign load_ready   = gnt_load;
  assign busy         = (state_q != StIdle);

`ifdef STORE_BUF_EN
  logic              sb_valid_q, sb_valid_d;
  logic [ADDR_W-1:0] sb_addr_q, sb_addr_d;
  logic [DATA_W-1:0] sb_data_q, sb_data_d;

  always_comb begin
    gnt_fetch = 1'b0;
    gnt_load  = 1'b0;
    gnt_drain = 1'b0;
    if (arb_en) begin
      if (fetch_forced)    gnt_fetch = 1'b1;
      else if (load_valid) gnt_load  = 1'b1;
      else if (sb_valid_q) gnt_drain = 1'b1;
      else if (fetch_valid) gnt_fetch = 1'b1;
    end
  end

  assign gnt_store   = 1'b0;
  assign load_hit    = sb_valid_q && (load_addr == sb_addr_q);
  // A store may refill the buffer in the very cycle its previous content is handed to the bus.
  assign store_ready = rst && (!sb_valid_q || gnt_drain);
  assign wr_addr     = sb_addr_q;
  assign wr_data     = sb_data_q;

  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
    if (gnt_drain) sb_valid_d = 1'b0;
    if (store_valid && store_ready) begin
      sb_valid_d = 1'b1;
      sb_addr_d  = store_addr;
      sb_data_d  = store_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid_q <= 1'b0;
      sb_addr_q  <= '0;
      sb_data_q  <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_addr_q  <= sb_addr_d;
      sb_data_q  <= sb_data_d;
    end
  end
`else
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_load  = 1'b0;
    gnt_store = 1'b0;
    if (arb_en) begin
      if (fetch_forced)     gnt_fetch = 1'b1;
      else if (store_valid) gnt_store = 1'b1;
      else if (load_valid)  gnt_load  = 1'b1;
      else if (fetch_valid) gnt_fetch = 1'b1;
    end
  end

  assign gnt_drain   = 1'b0;
  assign load_hit    = 1'b0;
  assign store_ready = gnt_store;
  assign wr_addr     = store_addr;
  assign wr_data     = store_data;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    id_d        = id_q;
    rw_d        = rw_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    bus_active  = 1'b0;
    bus_rw      = 1'b0;
    bus_commit  = 1'b0;
    bus_payload = '0;
    rsp_valid   = 1'b0;
    rsp_id      = 1'b0;
    rsp_data    = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_store || gnt_drain) begin
          addr_d  = wr_addr;
          data_d  = wr_data;
          rw_d    = 1'b1;
          state_d = StAddr;
        end else if (gnt_load && load_hit) begin
          data_d  = wr_data;
          id_d    = 1'b1;
          state_d = StRdRsp;
        end else if (gnt_load || gnt_fetch) begin
          addr_d  = gnt_load ? load_addr : fetch_addr;
          id_d    = gnt_load;
          rw_d    = 1'b0;
          state_d = StAddr;
        end
        if (gnt_fetch) begin
          starve_d = '0;
        end else if (arb_en && fetch_valid && (starve_q != StW'(STARVE_MAX))) begin
          starve_d = starve_q + 1'b1;
        end
      end
      StAddr: begin
        bus_active  = 1'b1;
        bus_rw      = rw_q;
        bus_payload = BUS_W'(addr_q);
        lat_d       = '0;
        state_d     = rw_q ? StStData : StRdWait;
      end
      StRdWait: begin
        if (lat_q == 2'(READ_LAT - 1)) begin
          data_d  = mem_in[DATA_W-1:0];
          state_d = StRdRsp;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StRdRsp: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = data_q;
        state_d   = StIdle;
      end
      StStData: begin
        bus_active  = 1'b1;
        bus_rw      = 1'b1;
        bus_commit  = 1'b1;
        bus_payload = BUS_W'(data_q);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      id_q     <= 1'b0;
      rw_q     <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rw_q     <= rw_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

endmodule
